// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory responder: multi-cycle word RAM with pipeline stall/done handshake.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module mem_stage_dmem #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadMEM,
  input  logic        MemWriteMEM,
  input  logic [31:0] ALUoutMEM,
  input  logic [31:0] memwritedataMEM,
  output logic [31:0] memreaddataMEM,
  output logic        memstall,
  output logic        memdone,
  output logic        memmisalign
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_store;
  logic [31:0]           r_rdata;
  logic                  r_done;
  logic                  r_misalign;
  logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];

  logic w_req;
  logic w_misal;
  logic w_last;
  logic w_wen;
  logic w_unused_addr;

  assign w_req  = MemReadMEM | MemWriteMEM;
  assign w_last = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  // Store commit is gated by reset so an aborted access never reaches the RAM.
  assign w_wen  = reset && w_last && r_store;
  assign w_unused_addr = ^{ALUoutMEM[31:ADDR_WIDTH+2], ALUoutMEM[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misal = |ALUoutMEM[1:0];
`else
  assign w_misal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_wen) r_mem[r_addr] <= r_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_store    <= 1'b0;
      r_rdata    <= 32'd0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= ALUoutMEM[ADDR_WIDTH+1:2];
            r_wdata <= memwritedataMEM;
            r_store <= MemWriteMEM;
            r_cnt   <= 4'(LATENCY - 1);
            if (w_misal) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_store) r_rdata <= r_mem[r_addr];
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign memstall       = ((r_state == S_IDLE) && w_req) || (r_state == S_ACCESS);
  assign memreaddataMEM = r_rdata;
  assign memdone        = r_done;
  assign memmisalign    = r_misalign;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Scoreboard bench for mem_stage_dmem: expected load data queued at issue, checked at memdone.
module tb_mem_stage_dmem;
  localparam int AW  = 8;
  localparam int LAT = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemReadMEM = 1'b0;
  logic        MemWriteMEM = 1'b0;
  logic [31:0] ALUoutMEM = 32'd0;
  logic [31:0] memwritedataMEM = 32'd0;
  logic [31:0] memreaddataMEM;
  logic        memstall;
  logic        memdone;
  logic        memmisalign;

  int errs = 0;
  int checks = 0;
  logic [31:0] mdl [256];
  logic [31:0] exp_rd = 32'd0;
  logic [31:0] sbq [$];

  mem_stage_dmem #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .MemReadMEM(MemReadMEM), .MemWriteMEM(MemWriteMEM),
    .ALUoutMEM(ALUoutMEM), .memwritedataMEM(memwritedataMEM),
    .memreaddataMEM(memreaddataMEM), .memstall(memstall),
    .memdone(memdone), .memmisalign(memmisalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one access at a negedge and follow it to memdone.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input bit from_done);
    bit mis;
    int idx, stalls, n;
    logic [31:0] e;
    mis = TRAP && (addr[1:0] != 2'b00);
    idx = int'(addr[AW+1:2]);
    MemReadMEM = !wr; MemWriteMEM = wr; ALUoutMEM = addr; memwritedataMEM = wd;
    if (from_done) begin
      #1 chk("done_nostall", memstall, 0);
      @(negedge clk);
    end
    if (!mis) begin
      if (wr) mdl[idx] = wd;
      else    exp_rd = mdl[idx];
    end
    sbq.push_back(exp_rd);
    #1;
    stalls = 0; n = 0;
    while (!memdone && n < 40) begin
      if (memstall) stalls++;
      @(negedge clk);
      n++;
    end
    e = sbq.pop_front();
    if (!memdone) chk("timeout", 0, 1);
    else begin
      chk("stall_cnt", stalls, mis ? 1 : LAT + 1);
      chk("done_lat",  n,      mis ? 1 : LAT + 1);
      chk("rdata",     memreaddataMEM, e);
      chk("misalign",  memmisalign, mis);
      chk("stall_done", memstall, 0);
    end
  endtask

  task automatic idle();
    MemReadMEM = 1'b0; MemWriteMEM = 1'b0;
    @(negedge clk);
    chk("idle_done", memdone, 0);
    chk("idle_stall", memstall, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdata", memreaddataMEM, 0);
    chk("rst_done", memdone, 0);
    chk("rst_mis", memmisalign, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("quiet_stall", memstall, 0);
      chk("quiet_done", memdone, 0);
      chk("quiet_rdata", memreaddataMEM, 0);
    end

    // Store then load same word
    access(1'b1, 32'h10, 32'hDEADBEEF, 1'b0); idle();
    access(1'b0, 32'h10, 32'h0, 1'b0); idle();

    // Preload two words, then back-to-back loads with strobes held
    access(1'b1, 32'h0, 32'h0BAD_F00D, 1'b0); idle();
    access(1'b1, 32'h4, 32'h1357_9BDF, 1'b0); idle();
    access(1'b0, 32'h0, 32'h0, 1'b0);
    access(1'b0, 32'h4, 32'h0, 1'b1); idle();
    chk("hold_rdata", memreaddataMEM, 32'h1357_9BDF);

    // Reset during ACCESS aborts a store
    access(1'b1, 32'h20, 32'h1111_1111, 1'b0); idle();
    MemWriteMEM = 1'b1; ALUoutMEM = 32'h20; memwritedataMEM = 32'h12345678;
    @(negedge clk);
    chk("abort_stall", memstall, 1);
    reset = 1'b0; MemWriteMEM = 1'b0;
    @(negedge clk);
    chk("abort_done", memdone, 0);
    chk("abort_rdata", memreaddataMEM, 0);
    reset = 1'b1; exp_rd = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_nodone", memdone, 0);
    end
    access(1'b0, 32'h20, 32'h0, 1'b0); idle();

    // Address wraps modulo RAM size
    access(1'b1, 32'h400, 32'hA5A5A5A5, 1'b0); idle();
    access(1'b0, 32'h000, 32'h0, 1'b0); idle();

    // Misaligned store: trapped or ignored low bits depending on build
    access(1'b1, 32'h13, 32'hCAFEF00D, 1'b0); idle();
    access(1'b0, 32'h10, 32'h0, 1'b0); idle();
    chk("mis_word", memreaddataMEM, TRAP ? 32'hDEADBEEF : 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage_dmem.md
Name: mem_stage_dmem

Overview:
- Data-memory responder at the MEM stage of the MIPS pipeline.
- Consumes the EX/MEM pipeline register outputs (read/write strobes, ALU address, store data) and services them with a multi-cycle word-addressed RAM.
- Returns load data to the MEM/WB path.
- Holds the front of the pipeline with a stall output until each access completes.

Parameters:
- ADDR_WIDTH, 8, word-address width; RAM depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles spent in ACCESS per request; legal range 1..15.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- MemReadMEM  input  1  load request from EX/MEM register.
- MemWriteMEM  input  1  store request from EX/MEM register.
- ALUoutMEM  input  32  byte address.
- memwritedataMEM  input  32  store data.
- memreaddataMEM  output  32  registered load data.
- memstall  output  1  stall request to PC, IF/ID, ID/EX and EX/MEM (hold when 1).
- memdone  output  1  one-cycle pulse; access finished this cycle.
- memmisalign  output  1  misaligned-access flag (see Optional Feature).

Behaviour:
- Reset (reset==0 at edge):
  - state=IDLE, cycle counter=0.
  - memreaddataMEM=0, memdone=0, memmisalign=0.
  - RAM contents are not cleared.
- Reset mid-operation aborts the access; a pending store is NOT committed.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req = MemReadMEM | MemWriteMEM.
  - If req: latch word address ALUoutMEM[ADDR_WIDTH+1:2], store data and op; counter=LATENCY-1; go to ACCESS.
  - If both strobes are 1, the op is a store.
- ACCESS:
  - Decrement counter each cycle.
  - When counter==0: a store writes the latched data into the RAM; a load captures RAM[addr] into memreaddataMEM. Then go to DONE.
- DONE:
  - memdone=1; inputs ignored; go to IDLE.
- memstall (combinational):
  - 1 when (state==IDLE && req) or state==ACCESS.
  - 0 in DONE, so the pipeline advances on the DONE edge.
- Timing: request first seen in IDLE at cycle 0 → stall cycles 0..LATENCY → memdone at cycle LATENCY+1.
- Back-to-back accesses: the next request is recognised in the IDLE cycle after DONE, giving one idle bubble between accesses.
- memreaddataMEM:
  - Updates only on load completion.
  - Holds its value through stores and idle cycles.
- Address width rules:
  - ALUoutMEM bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo RAM size.
  - Bits [1:0] are handled per Optional Feature.
- A load and a store to the same word in consecutive accesses: the load returns the newly stored value, because the store commits before the load starts.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A request with ALUoutMEM[1:0]!=0 goes IDLE→DONE directly (one stall cycle, memdone next cycle).
  - memmisalign=1 for that DONE cycle.
  - Stores are suppressed; memreaddataMEM is unchanged.
- Undefined:
  - Bits [1:0] are ignored and the access proceeds normally.
  - memmisalign is tied to 0.

Test Plan:
- Reset released, no requests → memstall=0, memdone=0, memreaddataMEM=0 for 10 cycles.
- LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 → store stalls 3 cycles, memdone in cycle 3; load returns 0xDEADBEEF on its memdone cycle.
- Loads to 0x0 then 0x4 held on inputs → two 3-cycle stall windows separated by one idle cycle; data matches preloaded words.
- Store 0x12345678 to 0x20, reset driven low during ACCESS, then load 0x20 → old value returned; memdone never pulses for the aborted store.
- ADDR_WIDTH=8: store 0xA5A5A5A5 to 0x400, load 0x000 → returns 0xA5A5A5A5 (wrap).
- DMEM_MISALIGN_TRAP_EN defined: store to 0x13 → memstall 1 cycle, memmisalign=1 with memdone; a later load of 0x10 shows an unchanged word. Undefined: the same store writes word 0x10.
